// File: rtl/deser_align_ctrl.sv
// Word-alignment controller for the 10-bit deserializer: hunts for K28.5,
// confirms the boundary over several commas, then emits aligned words.
module deser_align_ctrl #(
   parameter logic [9:0] COMMA_N       = 10'h17C,
   parameter logic [9:0] COMMA_P       = 10'h283,
   parameter int         LOCK_COMMAS   = 3,
   parameter int         ERR_LIMIT     = 4,
   parameter int         TIMEOUT_WORDS = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ip,
   input  logic       force_realign,
   output logic [9:0] op,
   output logic       word_valid,
   output logic       word_is_comma,
   output logic       locked,
   output logic       realign
);

   localparam int CW = $clog2(LOCK_COMMAS + 1);
   localparam int EW = $clog2(ERR_LIMIT + 1);
   localparam int TW = $clog2(TIMEOUT_WORDS + 1);
   localparam logic [CW-1:0] COMMA_MAX = CW'(LOCK_COMMAS);
   localparam logic [EW-1:0] ERR_MAX   = EW'(ERR_LIMIT);
   localparam logic [TW-1:0] TO_MAX    = TW'(TIMEOUT_WORDS);

   typedef enum logic [1:0] {
      HUNT    = 2'd0,
      CONFIRM = 2'd1,
      LOCKED  = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [9:0]      sr;
   logic [3:0]      phase_q, phase_d;
   logic [CW-1:0]   comma_cnt_q, comma_cnt_d;
   logic [EW-1:0]   err_cnt_q, err_cnt_d;
   logic [TW-1:0]   to_cnt_q, to_cnt_d;
   logic [9:0]      op_d;
   logic            word_valid_d, word_is_comma_d, realign_d;
   logic            comma_hit, aligned;

   assign comma_hit = (sr == COMMA_N) || (sr == COMMA_P);
   assign aligned   = (phase_q == 4'd0);

   always_comb begin
      state_d         = state_q;
      comma_cnt_d     = comma_cnt_q;
      err_cnt_d       = err_cnt_q;
      to_cnt_d        = to_cnt_q;
      phase_d         = (phase_q == 4'd9) ? 4'd0 : phase_q + 4'd1;
      op_d            = op;
      word_is_comma_d = word_is_comma;
      word_valid_d    = 1'b0;
      realign_d       = 1'b0;

      if (force_realign) begin
         // Phase keeps running; the next comma in HUNT re-anchors it anyway.
         state_d     = HUNT;
         comma_cnt_d = '0;
         err_cnt_d   = '0;
         to_cnt_d    = '0;
      end else begin
         unique case (state_q)
            HUNT: begin
               if (comma_hit) begin
                  phase_d     = 4'd1;
                  comma_cnt_d = CW'(1);
                  realign_d   = 1'b1;
                  err_cnt_d   = '0;
                  to_cnt_d    = '0;
                  state_d     = (LOCK_COMMAS <= 1) ? LOCKED : CONFIRM;
               end
            end
            CONFIRM: begin
               if (comma_hit && aligned) begin
                  if (comma_cnt_q >= COMMA_MAX - CW'(1)) begin
                     comma_cnt_d = COMMA_MAX;
                     err_cnt_d   = '0;
                     to_cnt_d    = '0;
                     state_d     = LOCKED;
                  end else begin
                     comma_cnt_d = comma_cnt_q + CW'(1);
                  end
               end else if (comma_hit) begin
                  phase_d     = 4'd1;
                  comma_cnt_d = CW'(1);
                  realign_d   = 1'b1;
               end
            end
            LOCKED: begin
               if (aligned) begin
                  op_d            = sr;
                  word_valid_d    = 1'b1;
                  word_is_comma_d = comma_hit;
                  if (comma_hit) begin
                     err_cnt_d = '0;
                     to_cnt_d  = '0;
                  end else if (to_cnt_q >= TO_MAX - TW'(1)) begin
                     to_cnt_d = TO_MAX;
                     state_d  = HUNT;
                  end else begin
                     to_cnt_d = to_cnt_q + TW'(1);
                  end
               end else if (comma_hit) begin
                  if (err_cnt_q >= ERR_MAX - EW'(1)) begin
                     err_cnt_d = ERR_MAX;
                     state_d   = HUNT;
                  end else begin
                     err_cnt_d = err_cnt_q + EW'(1);
                  end
               end
            end
            default: state_d = HUNT;
         endcase
      end
   end

   // locked follows the next state so it drops together with leaving LOCKED.
   always_ff @(posedge clk) begin
      if (rst) begin
         sr            <= '0;
         phase_q       <= '0;
         state_q       <= HUNT;
         comma_cnt_q   <= '0;
         err_cnt_q     <= '0;
         to_cnt_q      <= '0;
         op            <= '0;
         word_valid    <= 1'b0;
         word_is_comma <= 1'b0;
         locked        <= 1'b0;
         realign       <= 1'b0;
      end else begin
         sr            <= {ip, sr[9:1]};
         phase_q       <= phase_d;
         state_q       <= state_d;
         comma_cnt_q   <= comma_cnt_d;
         err_cnt_q     <= err_cnt_d;
         to_cnt_q      <= to_cnt_d;
         op            <= op_d;
         word_valid    <= word_valid_d;
         word_is_comma <= word_is_comma_d;
         locked        <= (state_d == LOCKED);
         realign       <= realign_d;
      end
   end

endmodule

// File: tb/tb_deser_align_ctrl.sv
// Self-checking bench for deser_align_ctrl: directed scenarios plus random
// streams, compared against a bit-history / anchor-time reference model.
module tb_deser_align_ctrl;

   localparam int M_HUNT = 0, M_CONFIRM = 1, M_LOCKED = 2;

   logic       clk = 1'b0;
   logic       rst, ip, force_realign;
   logic [9:0] op;
   logic       word_valid, word_is_comma, locked, realign;

   int checks = 0;
   int errors = 0;

   int         m_state, m_commas, m_errs, m_idle, anchor, edge_n;
   bit         hist[$];
   logic [9:0] e_op;
   logic       e_wv, e_wic, e_lk, e_ra;

   deser_align_ctrl dut (
      .clk           (clk),
      .rst           (rst),
      .ip            (ip),
      .force_realign (force_realign),
      .op            (op),
      .word_valid    (word_valid),
      .word_is_comma (word_is_comma),
      .locked        (locked),
      .realign       (realign)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [9:0] observed, input logic [9:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s at edge %0d: got 0x%03h expected 0x%03h", tag, edge_n, observed, expected);
      end
   endtask

   // The last ten received bits, oldest at bit 0.
   function automatic logic [9:0] window();
      int v = 0;
      for (int i = 0; i < 10; i++) v += int'(hist[i]) << i;
      return 10'(v);
   endfunction

   // Aligned edges are those a multiple of ten edges after the last anchor.
   task automatic modelStep(input logic b, input logic f, input logic r);
      logic [9:0] w;
      bit         hit, aligned;
      edge_n++;
      if (r) begin
         hist = {};
         repeat (10) hist.push_back(1'b0);
         m_state = M_HUNT; m_commas = 0; m_errs = 0; m_idle = 0;
         anchor = edge_n + 1;
         e_op = '0; e_wv = 0; e_wic = 0; e_lk = 0; e_ra = 0;
         return;
      end
      w       = window();
      hit     = (w == 10'h17C) || (w == 10'h283);
      aligned = ((edge_n - anchor) % 10) == 0;
      e_wv = 0;
      e_ra = 0;
      if (f) begin
         m_state = M_HUNT; m_commas = 0; m_errs = 0; m_idle = 0;
      end else if (m_state == M_HUNT) begin
         if (hit) begin
            anchor = edge_n; m_commas = 1; e_ra = 1; m_state = M_CONFIRM;
         end
      end else if (m_state == M_CONFIRM) begin
         if (hit && aligned) begin
            m_commas++;
            if (m_commas == 3) begin
               m_state = M_LOCKED; m_errs = 0; m_idle = 0;
            end
         end else if (hit) begin
            anchor = edge_n; m_commas = 1; e_ra = 1;
         end
      end else begin
         if (aligned) begin
            e_op = w; e_wv = 1; e_wic = hit;
            if (hit) begin
               m_errs = 0; m_idle = 0;
            end else begin
               m_idle++;
               if (m_idle == 16) m_state = M_HUNT;
            end
         end else if (hit) begin
            m_errs++;
            if (m_errs == 4) m_state = M_HUNT;
         end
      end
      hist.push_back(b);
      void'(hist.pop_front());
      e_lk = (m_state == M_LOCKED);
   endtask

   task automatic applyStimulus(input logic b, input logic f, input logic r);
      ip = b; force_realign = f; rst = r;
      @(posedge clk);
      modelStep(b, f, r);
      #1;
      checkOutput("op", op, e_op);
      checkOutput("word_valid", {9'd0, word_valid}, {9'd0, e_wv});
      checkOutput("locked", {9'd0, locked}, {9'd0, e_lk});
      checkOutput("realign", {9'd0, realign}, {9'd0, e_ra});
      if (e_wv) checkOutput("word_is_comma", {9'd0, word_is_comma}, {9'd0, e_wic});
   endtask

   task automatic sendWord(input logic [9:0] w, input logic force_first);
      for (int i = 0; i < 10; i++) applyStimulus(w[i], force_first && (i == 0), 1'b0);
   endtask

   task automatic checkResetValues(input string tag);
      checkOutput({tag, "_op"}, op, 10'h000);
      checkOutput({tag, "_wv"}, {9'd0, word_valid}, 10'd0);
      checkOutput({tag, "_locked"}, {9'd0, locked}, 10'd0);
      checkOutput({tag, "_realign"}, {9'd0, realign}, 10'd0);
   endtask

   initial begin
      int kind;
      logic [9:0] w;
      edge_n = 0;
      ip = 1'b0; force_realign = 1'b0; rst = 1'b1;

      applyStimulus(1'b0, 1'b0, 1'b1);
      applyStimulus(1'b0, 1'b0, 1'b1);
      repeat (20) applyStimulus(1'($urandom), 1'b0, 1'b0);
      repeat (3) applyStimulus(1'($urandom), 1'b0, 1'b1);
      checkResetValues("reset");

      // Acquisition: 7 zero bits then comma/data pairs.
      repeat (7) applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("pre_lock", {9'd0, locked}, 10'd0);
      repeat (4) begin
         sendWord(10'h17C, 1'b0);
         sendWord(10'h2AA, 1'b0);
      end
      checkOutput("acq_locked", {9'd0, locked}, 10'd1);

      // Both disparities while locked.
      repeat (3) begin
         sendWord(10'h17C, 1'b0);
         sendWord(10'h283, 1'b0);
      end
      checkOutput("disp_locked", {9'd0, locked}, 10'd1);
      checkOutput("disp_last_op", op, 10'h17C);

      // One-bit slip, then re-lock at the new boundary.
      applyStimulus(1'b0, 1'b0, 1'b0);
      repeat (10) begin
         sendWord(10'h17C, 1'b0);
         sendWord(10'h2AA, 1'b0);
      end
      checkOutput("slip_relock", {9'd0, locked}, 10'd1);

      // Timeout on a comma-free stream.
      repeat (17) sendWord(10'h2AA, 1'b0);
      checkOutput("timeout_unlock", {9'd0, locked}, 10'd0);

      // Re-lock, then force_realign on the edge of an aligned comma.
      repeat (4) begin
         sendWord(10'h17C, 1'b0);
         sendWord(10'h2AA, 1'b0);
      end
      checkOutput("relock", {9'd0, locked}, 10'd1);
      sendWord(10'h17C, 1'b0);
      sendWord(10'h2AA, 1'b1);
      checkOutput("force_unlock", {9'd0, locked}, 10'd0);

      applyStimulus(1'b1, 1'b1, 1'b1);
      checkResetValues("rst_force");

      // Random word mix with slips, forced realigns and occasional resets.
      for (int n = 0; n < 400; n++) begin
         kind = int'($urandom_range(0, 9));
         case (kind)
            0, 1, 2: w = 10'h17C;
            3:       w = 10'h283;
            4, 5, 6, 9: w = 10'h2AA;
            default: w = 10'($urandom);
         endcase
         if (kind == 8) begin
            repeat ($urandom_range(1, 3)) applyStimulus(1'($urandom), 1'b0, 1'b0);
         end
         if ($urandom_range(0, 149) == 0) applyStimulus(1'($urandom), 1'b0, 1'b1);
         sendWord(w, $urandom_range(0, 39) == 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
